// File: rtl/ram_burst_checker_pkg.sv
// ram_burst_checker_pkg
// Shared definitions for the RAM burst checker:
//   - state_t     : sequencer states
//   - MODE_*      : pattern mode encodings (2-bit mode input)
//   - pattern_gen : pattern word for a seed/index pair, computed at up to
//                   64 bits and masked to the caller's word width
package ram_burst_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        GAP,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'b00;
    localparam logic [1:0] MODE_INV   = 2'b01;
    localparam logic [1:0] MODE_WALK  = 2'b10;
    localparam logic [1:0] MODE_CONST = 2'b11;

    // Width-generic pattern generator. All arithmetic is done in 64 bits and
    // masked to 'width' so sums wrap modulo 2**width and the rotate stays
    // inside the word. A shift by 'width' yields zero, which covers the
    // rotate-by-zero case.
    function automatic logic [63:0] pattern_gen(
        input logic [1:0]  mode,
        input logic [63:0] seed,
        input logic [31:0] idx,
        input int unsigned width
    );
        logic [63:0] mask;
        logic [63:0] s;
        logic [63:0] sum;
        logic [63:0] result;
        int unsigned sh;
        mask   = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        s      = seed & mask;
        sum    = (s + 64'(idx)) & mask;
        sh     = idx % width;
        case (mode)
            MODE_INC:  result = sum;
            MODE_INV:  result = ~sum & mask;
            MODE_WALK: result = ((s << sh) | (s >> (width - sh))) & mask;
            default:   result = s;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ram_burst_checker_sdp_ram.sv
// sdp_ram
// Inferred simple dual-port RAM, one write port and one read port on the
// same clock. Read data is registered (1-cycle latency) and the output
// register only loads when rden_i is high, so it holds the last word read.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (output reg only)
//   wren_i        : write enable
//   wraddress_i   : write address
//   wrdata_i      : write data
//   rden_i        : read enable
//   rdaddress_i   : read address
//   q_o           : registered read data
module sdp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wren_i,
    input  logic [ADDR_W-1:0] wraddress_i,
    input  logic [DATA_W-1:0] wrdata_i,
    input  logic              rden_i,
    input  logic [ADDR_W-1:0] rdaddress_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] q_q;

    // The array itself has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wren_i) begin
            mem[wraddress_i] <= wrdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (rden_i) begin
            q_q <= mem[rdaddress_i];
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ram_burst_checker.sv
// ram_burst_checker
// Writes a burst of pattern words into an internal simple dual-port RAM,
// idles for GAP_CYC cycles, reads the burst back and compares each word
// against the regenerated pattern. Optionally repeats runs with an
// incrementing seed until stop.
// Build option: define INJECT_ERR_EN to add the inject_err input, which
// flips bit 0 of the first written word of a run.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begins a run when idle (latches base_addr/seed/mode/continuous)
//   continuous      : repeat runs until stop
//   stop            : end continuous mode after the current run
//   base_addr, seed, mode : burst configuration
//   busy, done, pass      : run status
//   err_cnt, first_err_addr : mismatch statistics since last start
//   rd_data         : last word read from the RAM
module ram_burst_checker
    import ram_burst_checker_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 10,
    parameter int BURST_LEN = 11,
    parameter int GAP_CYC   = 19,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef INJECT_ERR_EN
    input  logic                 inject_err,
`endif
    input  logic                 continuous,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [DATA_W-1:0]    seed,
    input  logic [1:0]           mode,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int GAP_W = 17;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [DATA_W-1:0]     seed_q, seed_d;
    logic [1:0]            mode_q, mode_d;
    logic                  cont_q, cont_d;
    logic                  stop_q, stop_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  vld_q, vld_d;
    logic [DATA_W-1:0]     exp_q, exp_d;
    logic [ADDR_W-1:0]     exp_addr_q, exp_addr_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]     first_err_q, first_err_d;
    logic                  first_seen_q, first_seen_d;
    logic                  run_mis_q, run_mis_d;
    logic                  pass_q, pass_d;
`ifdef INJECT_ERR_EN
    logic                  inject_q, inject_d;
`endif

    logic                  ram_wren, ram_rden;
    logic [ADDR_W-1:0]     ram_wraddr, ram_rdaddr;
    logic [DATA_W-1:0]     ram_wrdata, ram_q;
    logic [ADDR_W-1:0]     cur_addr;
    logic [DATA_W-1:0]     pat_word;
    logic                  last_idx;
    logic                  mismatch;

    // Address wraps naturally through the ADDR_W-bit add.
    assign cur_addr = base_q + idx_q[ADDR_W-1:0];
    assign pat_word = DATA_W'(pattern_gen(mode_q, 64'(seed_q), 32'(idx_q), DATA_W));
    assign last_idx = (idx_q == IDX_W'(BURST_LEN - 1));
    assign mismatch = vld_q && (ram_q != exp_q);

    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .wren_i      (ram_wren),
        .wraddress_i (ram_wraddr),
        .wrdata_i    (ram_wrdata),
        .rden_i      (ram_rden),
        .rdaddress_i (ram_rdaddr),
        .q_o         (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        seed_d       = seed_q;
        mode_d       = mode_q;
        cont_d       = cont_q;
        stop_d       = stop_q | stop;
        idx_d        = idx_q;
        gap_d        = gap_q;
        vld_d        = 1'b0;
        exp_d        = pat_word;
        exp_addr_d   = cur_addr;
        err_cnt_d    = err_cnt_q;
        first_err_d  = first_err_q;
        first_seen_d = first_seen_q;
        run_mis_d    = run_mis_q;
        pass_d       = pass_q;
`ifdef INJECT_ERR_EN
        inject_d     = inject_q;
`endif
        ram_wren     = 1'b0;
        ram_rden     = 1'b0;
        ram_wraddr   = cur_addr;
        ram_rdaddr   = cur_addr;
        ram_wrdata   = pat_word;

        // Compare stage: exp_q/exp_addr_q were captured alongside the read.
        if (mismatch) begin
            run_mis_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (!first_seen_q) begin
                first_err_d  = exp_addr_q;
                first_seen_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d       = base_addr;
                    seed_d       = seed;
                    mode_d       = mode;
                    cont_d       = continuous;
                    stop_d       = stop;
                    err_cnt_d    = '0;
                    first_err_d  = '0;
                    first_seen_d = 1'b0;
                    run_mis_d    = 1'b0;
                    pass_d       = 1'b0;
                    idx_d        = '0;
`ifdef INJECT_ERR_EN
                    inject_d     = inject_err;
`endif
                    state_d      = WRITE;
                end
            end
            WRITE: begin
                ram_wren = 1'b1;
`ifdef INJECT_ERR_EN
                if (inject_q && (idx_q == '0)) begin
                    ram_wrdata[0] = ~pat_word[0];
                end
`endif
                idx_d = idx_q + IDX_W'(1);
                if (last_idx) begin
                    idx_d   = '0;
                    gap_d   = '0;
                    state_d = (GAP_CYC == 0) ? READ : GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    state_d = READ;
                end
            end
            READ: begin
                ram_rden = 1'b1;
                vld_d    = 1'b1;
                idx_d    = idx_q + IDX_W'(1);
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Include the final word's compare, which resolves this cycle.
                pass_d  = !(run_mis_q | mismatch);
                state_d = DONE;
            end
            DONE: begin
                run_mis_d = 1'b0;
`ifdef INJECT_ERR_EN
                inject_d  = 1'b0;
`endif
                if (cont_q && !(stop_q | stop)) begin
                    // New seed per run so a stale RAM image cannot pass.
                    seed_d  = seed_q + DATA_W'(1);
                    idx_d   = '0;
                    state_d = WRITE;
                end else begin
                    stop_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q       <= '0;
            seed_q       <= '0;
            mode_q       <= '0;
            cont_q       <= 1'b0;
            stop_q       <= 1'b0;
            idx_q        <= '0;
            gap_q        <= '0;
            vld_q        <= 1'b0;
            exp_q        <= '0;
            exp_addr_q   <= '0;
            err_cnt_q    <= '0;
            first_err_q  <= '0;
            first_seen_q <= 1'b0;
            run_mis_q    <= 1'b0;
            pass_q       <= 1'b0;
`ifdef INJECT_ERR_EN
            inject_q     <= 1'b0;
`endif
        end else begin
            base_q       <= base_d;
            seed_q       <= seed_d;
            mode_q       <= mode_d;
            cont_q       <= cont_d;
            stop_q       <= stop_d;
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            vld_q        <= vld_d;
            exp_q        <= exp_d;
            exp_addr_q   <= exp_addr_d;
            err_cnt_q    <= err_cnt_d;
            first_err_q  <= first_err_d;
            first_seen_q <= first_seen_d;
            run_mis_q    <= run_mis_d;
            pass_q       <= pass_d;
`ifdef INJECT_ERR_EN
            inject_q     <= inject_d;
`endif
        end
    end

    assign busy           = (state_q != IDLE) && (state_q != DONE);
    assign done           = (state_q == DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;
    assign rd_data        = ram_q;

endmodule

// File: tb/tb_ram_burst_checker.sv
// Directed bench for ram_burst_checker at default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_burst_checker;

    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int BL  = 11;
    localparam int GAP = 19;
    localparam int EW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] seed = '0;
    logic [1:0]    mode = '0;
`ifdef INJECT_ERR_EN
    logic          inject_err = 1'b0;
`endif
    logic          busy, done, pass;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    ram_burst_checker #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .BURST_LEN (BL),
        .GAP_CYC   (GAP),
        .ERR_CNT_W (EW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
`ifdef INJECT_ERR_EN
        .inject_err     (inject_err),
`endif
        .continuous     (continuous),
        .stop           (stop),
        .base_addr      (base_addr),
        .seed           (seed),
        .mode           (mode),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .rd_data        (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference pattern, rotate done bit by bit.
    function automatic logic [15:0] pat(input logic [1:0] md, input logic [15:0] sd, input int i);
        logic [15:0] r;
        case (md)
            2'b00: r = sd + 16'(i);
            2'b01: r = ~(sd + 16'(i));
            2'b10: begin
                r = sd;
                for (int k = 0; k < (i % 16); k++) r = {r[14:0], r[15]};
            end
            default: r = sd;
        endcase
        return r;
    endfunction

    task automatic run_once(input logic [AW-1:0] base, input logic [15:0] sd, input logic [1:0] md,
                            input bit inj, input bit exp_pass, input int exp_err,
                            input logic [AW-1:0] exp_first, output logic [15:0] last_wdata);
        int wi, ri, riss, ndone, done_cyc, first_rd;
        logic rd_pend;
        logic [15:0] w;
        wi = 0; ri = 0; riss = 0; ndone = 0; done_cyc = -1; first_rd = -1;
        rd_pend = 1'b0; last_wdata = '0;
        @(negedge clk);
        base_addr = base; seed = sd; mode = md; continuous = 1'b0; start = 1'b1;
`ifdef INJECT_ERR_EN
        inject_err = inj;
`endif
        for (int cyc = 1; cyc <= 2*BL + GAP + 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
`ifdef INJECT_ERR_EN
                inject_err = 1'b0;
`endif
                chk("busy_after_start", busy, 1);
            end
            // A start while busy must not disturb the run.
            if (cyc == 5) begin start = 1'b1; base_addr = base + 10'd7; end
            if (cyc == 6) begin start = 1'b0; base_addr = base; end
            if (rd_pend) begin
                w = pat(md, sd, ri) ^ {15'd0, (inj && ri == 0)};
                chk("rd_data", rd_data, w);
                ri++;
            end
            rd_pend = dut.ram_rden;
            if (dut.ram_rden) begin
                if (first_rd < 0) first_rd = cyc;
                chk("rd_addr", dut.ram_rdaddr, AW'(base + riss));
                riss++;
            end
            if (dut.ram_wren) begin
                w = pat(md, sd, wi) ^ {15'd0, (inj && wi == 0)};
                chk("wr_addr", dut.ram_wraddr, AW'(base + wi));
                chk("wr_data", dut.ram_wrdata, w);
                last_wdata = dut.ram_wrdata;
                wi++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("busy_at_done", busy, 0);
                chk("pass", pass, exp_pass);
                chk("err_cnt", err_cnt, exp_err);
                chk("first_err_addr", first_err_addr, exp_first);
            end
        end
        chk("write_count", wi, BL);
        chk("read_count", ri, BL);
        chk("first_read_cycle", first_rd, BL + GAP + 1);
        chk("done_cycle", done_cyc, 2*BL + GAP + 2);
        chk("done_pulses", ndone, 1);
        chk("busy_end", busy, 0);
        $display("run base=%0d seed=0x%0h mode=%0d inj=%0d: writes=%0d reads=%0d done@%0d pass=%0d err=%0d",
                 base, sd, md, inj, wi, ri, done_cyc, pass, err_cnt);
    endtask

    initial begin
        logic [15:0] lw;
        int ndone, cyc_lim, got_rd;
        bit stop_sent;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_first_err", first_err_addr, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Incrementing, base 20, seed 0: last word 10
        run_once(10'd20, 16'h0000, 2'b00, 1'b0, 1'b1, 0, 10'd0, lw);
        chk("inc_last_word", lw, 16'h000A);

        // Address wrap 1020..1023, 0..6
        run_once(10'd1020, 16'h0200, 2'b00, 1'b0, 1'b1, 0, 10'd0, lw);
        chk("wrap_last_word", lw, 16'h020A);

        // Walking one from seed 1: 0x0001 .. 0x0400
        run_once(10'd64, 16'h0001, 2'b10, 1'b0, 1'b1, 0, 10'd0, lw);
        chk("walk_last_word", lw, 16'h0400);

        // Inverted from seed 0: 0xFFFF, 0xFFFE, ... 0xFFF5
        run_once(10'd200, 16'h0000, 2'b01, 1'b0, 1'b1, 0, 10'd0, lw);
        chk("inv_last_word", lw, 16'hFFF5);

        // Constant
        run_once(10'd900, 16'hBEEF, 2'b11, 1'b0, 1'b1, 0, 10'd0, lw);
        chk("const_last_word", lw, 16'hBEEF);

`ifdef INJECT_ERR_EN
        // One injected error at the first address
        run_once(10'd100, 16'h0000, 2'b00, 1'b1, 1'b0, 1, 10'd100, lw);
        chk("inject_last_word", lw, 16'h000A);
`endif

        // Continuous: stop during the third run's WRITE
        @(negedge clk);
        base_addr = 10'd300; seed = 16'h1000; mode = 2'b00; continuous = 1'b1; start = 1'b1;
        ndone = 0; stop_sent = 1'b0;
        cyc_lim = 4 * (2*BL + GAP + 2) + 20;
        for (int cyc = 1; cyc <= cyc_lim; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin start = 1'b0; continuous = 1'b0; end
            if (stop) stop = 1'b0;
            if (dut.ram_wren && dut.ram_wraddr == 10'd300) begin
                chk("cont_first_word", dut.ram_wrdata, 16'h1000 + 16'(ndone));
                $display("continuous run %0d first word 0x%0h", ndone, dut.ram_wrdata);
            end
            if (ndone == 2 && dut.ram_wren && !stop_sent) begin
                stop = 1'b1;
                stop_sent = 1'b1;
            end
            if (done) begin
                ndone++;
                chk("cont_pass", pass, 1);
                chk("cont_err_cnt", err_cnt, 0);
            end
        end
        chk("cont_done_pulses", ndone, 3);
        chk("cont_busy_end", busy, 0);
        chk("cont_err_end", err_cnt, 0);
        $display("continuous: done pulses=%0d err=%0d", ndone, err_cnt);

        // Reset in the middle of READ
        @(negedge clk);
        base_addr = 10'd500; seed = 16'h0055; mode = 2'b11; start = 1'b1;
        got_rd = 0;
        for (int cyc = 1; cyc <= 60 && got_rd == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start = 1'b0;
            if (dut.ram_rden) got_rd = 1;
        end
        chk("reached_read", got_rd, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_first_err", first_err_addr, 0);
        chk("midrst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_idle", busy, 0);
        $display("mid-read reset: done pulses after reset=%0d", ndone);

        run_once(10'd40, 16'h00AB, 2'b00, 1'b0, 1'b1, 0, 10'd0, lw);
        chk("post_rst_last_word", lw, 16'h00B5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
